// File: rtl/matrix_writeback.sv
// Serialises a packed matrix-multiply result into the register file, one element per
// accepted write, with programmable base register, write order and write-port backpressure.
module matrix_writeback #(
  parameter int DATA_W     = 8,
  parameter int NUM_ELEM   = 4,
  parameter int REG_ADDR_W = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_ELEM*DATA_W-1:0]   result,
  input  logic [REG_ADDR_W-1:0]        base_reg,
  input  logic                         order,
  input  logic                         wr_ready,
  output logic                         wr_en,
  output logic [REG_ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic                         busy,
  output logic                         done
);

  localparam int CNT_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int SUM_W = ((REG_ADDR_W > CNT_W) ? REG_ADDR_W : CNT_W) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                       state_q;
  logic [NUM_ELEM*DATA_W-1:0]   result_q;
  logic [REG_ADDR_W-1:0]        base_q;
  logic                         order_q;
  logic [CNT_W-1:0]             idx_q;
  logic                         wr_en_q;
  logic [REG_ADDR_W-1:0]        wr_addr_q;
  logic [DATA_W-1:0]            wr_data_q;
  logic                         busy_q;
  logic                         done_q;

  logic [CNT_W-1:0]             first_idx_s;
  logic [CNT_W-1:0]             next_idx_s;
  logic                         last_s;

  function automatic logic [DATA_W-1:0] elem_at(
    input logic [NUM_ELEM*DATA_W-1:0] vec,
    input logic [CNT_W-1:0]           idx
  );
    logic [DATA_W-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      if (idx == CNT_W'(i)) begin
        e = vec[i*DATA_W +: DATA_W];
      end else begin
        e = e;
      end
    end
    return e;
  endfunction

  // Address wraps silently modulo the register-file size.
  function automatic logic [REG_ADDR_W-1:0] addr_of(
    input logic [REG_ADDR_W-1:0] base,
    input logic [CNT_W-1:0]      idx
  );
    return REG_ADDR_W'(SUM_W'(base) + SUM_W'(idx));
  endfunction

  // Index walk: first element from the live order input, successors from the captured order.
  always_comb begin
    first_idx_s = '0;
    next_idx_s  = idx_q;
    last_s      = 1'b0;
    if (order) begin
      first_idx_s = LAST_IDX;
    end else begin
      first_idx_s = '0;
    end
    if (order_q) begin
      next_idx_s = idx_q - CNT_W'(1);
      last_s     = (idx_q == '0);
    end else begin
      next_idx_s = idx_q + CNT_W'(1);
      last_s     = (idx_q == LAST_IDX);
    end
  end

  // Control FSM with registered write-port and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      base_q    <= '0;
      order_q   <= 1'b0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            result_q  <= result;
            base_q    <= base_reg;
            order_q   <= order;
            idx_q     <= first_idx_s;
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_of(base_reg, first_idx_s);
            wr_data_q <= elem_at(result, first_idx_s);
            busy_q    <= 1'b1;
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wr_ready) begin
            if (last_s) begin
              wr_en_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q     <= next_idx_s;
              wr_addr_q <= addr_of(base_q, next_idx_s);
              wr_data_q <= elem_at(result_q, next_idx_s);
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_matrix_writeback.sv
// Scoreboard bench for matrix_writeback: expected writes are queued when a start is driven
// and matched against the writes the DUT actually gets accepted.
module tb_matrix_writeback;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] result;
  logic [2:0]  base_reg;
  logic        order;
  logic        wr_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;

  typedef struct {
    logic       en;
    logic [2:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  wr_t         stall_q[$];
  int          n_cmp;
  int          n_fail;
  int          done_cnt;
  int          done_cyc;
  logic [31:0] busy_vec;

  matrix_writeback #(.DATA_W(8), .NUM_ELEM(4), .REG_ADDR_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .result   (result),
    .base_reg (base_reg),
    .order    (order),
    .wr_ready (wr_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected writes for one operation; cycles are counted from the start edge.
  task automatic push_exp(input logic [31:0] res, input logic [2:0] base, input logic ord,
                          input int cyc0, input int stall_at, input int stall_len);
    for (int k = 0; k < 4; k++) begin
      int  idx;
      wr_t e;
      idx    = ord ? 3 - k : k;
      e.en   = 1'b1;
      e.addr = base + 3'(idx);
      e.data = res[idx*8 +: 8];
      e.cyc  = cyc0 + k + 1 + ((stall_at >= 0 && k >= stall_at) ? stall_len : 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [31:0] res, input logic [2:0] base, input logic ord);
    start    = 1'b1;
    result   = res;
    base_reg = base;
    order    = ord;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs ncyc cycles, recording accepted writes, stalled outputs, busy and done.
  task automatic collect(input int ncyc, input int stall_at, input int stall_len,
                         input int inj_cyc, input logic [31:0] inj_res,
                         input logic [2:0] inj_base, input logic inj_ord);
    int  acc;
    int  stalled;
    wr_t w;
    acc = 0; stalled = 0; done_cnt = 0; done_cyc = -1; busy_vec = 32'h0;
    stall_q.delete();
    for (int c = 1; c <= ncyc; c++) begin
      busy_vec[c] = busy;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      start = (c == inj_cyc);
      if (c == inj_cyc) begin
        result = inj_res; base_reg = inj_base; order = inj_ord;
      end
      w.en = wr_en; w.addr = wr_addr; w.data = wr_data; w.cyc = c;
      if (wr_en && acc == stall_at && stalled < stall_len) begin
        wr_ready = 1'b0;
        stalled++;
        stall_q.push_back(w);
      end else begin
        wr_ready = 1'b1;
      end
      if (wr_en && wr_ready) begin
        obs_q.push_back(w);
        acc++;
      end
      @(negedge clk);
    end
    start    = 1'b0;
    wr_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; result = 32'h0; base_reg = 3'd0; order = 1'b0; wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, busy, done} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h busy=%b done=%b, want all 0",
               wr_en, wr_addr, wr_data, busy, done);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({wr_en, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got en=%b busy=%b done=%b, want 000", wr_en, busy, done);
    end
  endtask

  task automatic test_ascending();
    wr_t e, o;
    push_exp(32'hDDCCBBAA, 3'd0, 1'b0, 0, -1, 0);
    pulse_start(32'hDDCCBBAA, 3'd0, 1'b0);
    collect(8, -1, 0, 0, 32'h0, 3'd0, 1'b0);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL asc_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        n_fail++;
        $display("FAIL asc_write: got (%0d,%h)@%0d, want (%0d,%h)@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== 5) begin
      n_fail++; $display("FAIL asc_done: got %0d pulses last@%0d, want 1@5", done_cnt, done_cyc);
    end
    n_cmp++;
    if (busy_vec !== 32'h0000003E) begin
      n_fail++; $display("FAIL asc_busy: got %h, want 0000003e", busy_vec);
    end
  endtask

  task automatic test_descending();
    wr_t e, o;
    push_exp(32'hDDCCBBAA, 3'd2, 1'b1, 0, -1, 0);
    pulse_start(32'hDDCCBBAA, 3'd2, 1'b1);
    collect(8, -1, 0, 0, 32'h0, 3'd0, 1'b0);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL desc_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        n_fail++;
        $display("FAIL desc_write: got (%0d,%h)@%0d, want (%0d,%h)@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== 5) begin
      n_fail++; $display("FAIL desc_done: got %0d pulses last@%0d, want 1@5", done_cnt, done_cyc);
    end
  endtask

  task automatic test_wrap();
    wr_t e, o;
    push_exp(32'hDDCCBBAA, 3'd6, 1'b0, 0, -1, 0);
    pulse_start(32'hDDCCBBAA, 3'd6, 1'b0);
    collect(8, -1, 0, 0, 32'h0, 3'd0, 1'b0);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL wrap_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        n_fail++;
        $display("FAIL wrap_write: got (%0d,%h)@%0d, want (%0d,%h)@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    wr_t e, o;
    push_exp(32'hDDCCBBAA, 3'd0, 1'b0, 0, 1, 3);
    pulse_start(32'hDDCCBBAA, 3'd0, 1'b0);
    collect(10, 1, 3, 0, 32'h0, 3'd0, 1'b0);
    n_cmp++;
    if (stall_q.size() !== 3) begin
      n_fail++; $display("FAIL bp_stall_count: got %0d stalled cycles, want 3", stall_q.size());
    end
    while (stall_q.size() > 0) begin
      o = stall_q.pop_front(); n_cmp++;
      if (o.en !== 1'b1 || o.addr !== 3'd1 || o.data !== 8'hBB) begin
        n_fail++;
        $display("FAIL bp_hold: got en=%b (%0d,%h)@%0d, want en=1 (1,bb)", o.en, o.addr, o.data, o.cyc);
      end
    end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        n_fail++;
        $display("FAIL bp_write: got (%0d,%h)@%0d, want (%0d,%h)@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== 8) begin
      n_fail++; $display("FAIL bp_done: got %0d pulses last@%0d, want 1@8", done_cnt, done_cyc);
    end
    n_cmp++;
    if (busy_vec !== 32'h000001FE) begin
      n_fail++; $display("FAIL bp_busy: got %h, want 000001fe", busy_vec);
    end
  endtask

  task automatic test_ignore_start();
    wr_t e, o;
    push_exp(32'h5A3C9617, 3'd1, 1'b0, 0, -1, 0);
    pulse_start(32'h5A3C9617, 3'd1, 1'b0);
    collect(9, -1, 0, 2, 32'h0, 3'd5, 1'b1);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL ign_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        n_fail++;
        $display("FAIL ign_write: got (%0d,%h)@%0d, want (%0d,%h)@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== 5) begin
      n_fail++; $display("FAIL ign_done: got %0d pulses last@%0d, want 1@5", done_cnt, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    wr_t e, o;
    push_exp(32'hDDCCBBAA, 3'd0, 1'b0, 0, -1, 0);
    push_exp(32'h44332211, 3'd1, 1'b1, 6, -1, 0);
    pulse_start(32'hDDCCBBAA, 3'd0, 1'b0);
    collect(13, -1, 0, 6, 32'h44332211, 3'd1, 1'b1);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        n_fail++;
        $display("FAIL b2b_write: got (%0d,%h)@%0d, want (%0d,%h)@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (done_cnt !== 2 || done_cyc !== 11) begin
      n_fail++; $display("FAIL b2b_done: got %0d pulses last@%0d, want 2@11", done_cnt, done_cyc);
    end
    n_cmp++;
    if (busy_vec !== 32'h00000FBE) begin
      n_fail++; $display("FAIL b2b_busy: got %h, want 00000fbe", busy_vec);
    end
  endtask

  task automatic test_reset_abort();
    wr_t e, o;
    int  found;
    int  spurious;
    found = 0; spurious = 0;
    pulse_start(32'hDDCCBBAA, 3'd0, 1'b0);
    for (int c = 1; c <= 8 && found == 0; c++) begin
      wr_ready = 1'b1;
      if (wr_en && wr_addr == 3'd2) begin
        found = 1;
      end else begin
        @(negedge clk);
      end
    end
    n_cmp++;
    if (found !== 1) begin
      n_fail++; $display("FAIL abort_reach: element 2 never presented, got found=%0d want 1", found);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, busy, done} !== 14'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: got en=%b addr=%0d data=%h busy=%b done=%b, want all 0",
               wr_en, wr_addr, wr_data, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (wr_en || busy || done) spurious++;
      @(negedge clk);
    end
    n_cmp++;
    if (spurious !== 0) begin
      n_fail++; $display("FAIL abort_idle: got %0d active cycles after release, want 0", spurious);
    end
    push_exp(32'h87654321, 3'd3, 1'b0, 0, -1, 0);
    pulse_start(32'h87654321, 3'd3, 1'b0);
    collect(8, -1, 0, 0, 32'h0, 3'd0, 1'b0);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL abort_fresh_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
        n_fail++;
        $display("FAIL abort_fresh_write: got (%0d,%h)@%0d, want (%0d,%h)@%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== 5) begin
      n_fail++; $display("FAIL abort_fresh_done: got %0d pulses last@%0d, want 1@5", done_cnt, done_cyc);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_ascending();
    test_descending();
    test_wrap();
    test_backpressure();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_writeback.md
Name: matrix_writeback

Overview:
- Parametrised serialiser that writes a packed multi-element matrix result into the register file, one element per accepted write.
- Sits between the matrix-multiply unit and the register-file write port of the pipeline.
- Captures the full result on a start pulse.
- Supports a programmable base register, ascending or descending write order, write-port backpressure, and a completion pulse.

Parameters:
- DATA_W, 8, width of one element and of the register-file write data.
- NUM_ELEM, 4, number of elements in the packed result (>=1).
- REG_ADDR_W, 3, register-file address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin write-back; sampled only in IDLE.
- result  in  NUM_ELEM*DATA_W  packed result; element i = result[i*DATA_W +: DATA_W].
- base_reg  in  REG_ADDR_W  destination register for element 0.
- order  in  1  0 = element 0 first (ascending); 1 = element NUM_ELEM-1 first (descending).
- wr_ready  in  1  register-file port can accept a write this cycle.
- wr_en  out  1  write request valid.
- wr_addr  out  REG_ADDR_W  destination register.
- wr_data  out  DATA_W  element being written.
- busy  out  1  high in WRITE and DONE states.
- done  out  1  one-cycle pulse after the last write is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0; element counter=0. A reset mid-operation aborts immediately, with no further writes and no done pulse.
- All outputs are registered.
- States: IDLE, WRITE, DONE.
- IDLE, on start=1:
  - Capture result, base_reg and order into internal registers.
  - Next state = WRITE.
  - On the same edge, load the first element: wr_en=1, busy=1, wr_data=first element, wr_addr=its address.
  - Latency from the start edge to the first wr_en = 1 cycle.
- Address rule: wr_addr = (captured base_reg + element index) mod 2^REG_ADDR_W. Wrap-around is silent, e.g. REG_ADDR_W=3 with base 6 gives addresses 6, 7, 0, 1.
- Element index sequence:
  - Ascending: 0..NUM_ELEM-1.
  - Descending: NUM_ELEM-1..0, so addresses descend.
  - In both orders the address is always tied to the element index.
- Handshake:
  - A write is accepted on an edge where wr_en=1 and wr_ready=1.
  - While wr_en=1 and wr_ready=0, wr_en, wr_addr and wr_data hold stable.
  - On acceptance of a non-last element, the next element and address are presented on the following cycle with no bubble.
- Last element accepted: wr_en=0 and state=DONE; done=1 for exactly one cycle with busy still 1; then IDLE with busy=0 and done=0.
- With wr_ready held at 1: writes occupy cycles 1..NUM_ELEM after start, done is high in cycle NUM_ELEM+1, and the next start is accepted from cycle NUM_ELEM+2.
- start while busy (WRITE or DONE) is ignored, with no re-capture.
- Changes to result, base_reg or order after capture have no effect on the writes in progress.
- NUM_ELEM=1: a single write, then DONE.
- Counter width is clog2(NUM_ELEM), minimum 1.

Test Plan:
- Reset with DATA_W=8, NUM_ELEM=4, result=32'hDDCCBBAA, base_reg=0, order=0, wr_ready=1, start pulse -> writes (0,AA), (1,BB), (2,CC), (3,DD) in consecutive cycles 1-4; done pulse in cycle 5; busy high in cycles 1-5.
- Same stimulus with order=1, base_reg=2 -> writes (5,DD), (4,CC), (3,BB), (2,AA); done once.
- base_reg=6, order=0 -> addresses 6, 7, 0, 1 with data AA, BB, CC, DD.
- wr_ready low for 3 cycles while presenting element 1 -> wr_en/wr_addr/wr_data stay at (1,BB) for those cycles; total of exactly 4 accepted writes; done is delayed by 3 cycles.
- Change result to 0 and pulse start again during WRITE -> original data still written, second start ignored, exactly one done pulse.
- Assert reset low while presenting element 2 -> all outputs go to 0 immediately; after release, state is IDLE with no done pulse; a fresh start completes normally.
